// File: rtl/alu_issue_pkg.sv
// Shared ALU constants, instruction field layout and issue bundle type.
// Imported by the issue stage, its decoder and its interface.
package alu_issue_pkg;

    localparam int REG_SIZE    = 32;
    localparam int OPCODE_SIZE = 4;
    localparam int REG_ADDR_W  = 5;
    localparam int INSTR_W     = 32;
    localparam int FUNCT_W     = 4;
    localparam int IMM_W       = 12;

    localparam logic [OPCODE_SIZE-1:0] ALU_AND = 4'd0;
    localparam logic [OPCODE_SIZE-1:0] ALU_ORR = 4'd1;
    localparam logic [OPCODE_SIZE-1:0] ALU_ADD = 4'd2;
    localparam logic [OPCODE_SIZE-1:0] ALU_SUB = 4'd3;
    localparam logic [OPCODE_SIZE-1:0] ALU_XOR = 4'd4;
    localparam logic [OPCODE_SIZE-1:0] ALU_NOR = 4'd5;
    localparam logic [OPCODE_SIZE-1:0] ALU_LSL = 4'd6;
    localparam logic [OPCODE_SIZE-1:0] ALU_LSR = 4'd7;

    localparam logic [FUNCT_W-1:0] FUNCT_AND = 4'd0;
    localparam logic [FUNCT_W-1:0] FUNCT_ORR = 4'd1;
    localparam logic [FUNCT_W-1:0] FUNCT_ADD = 4'd2;
    localparam logic [FUNCT_W-1:0] FUNCT_SUB = 4'd3;
    localparam logic [FUNCT_W-1:0] FUNCT_XOR = 4'd4;
    localparam logic [FUNCT_W-1:0] FUNCT_NOR = 4'd5;
    localparam logic [FUNCT_W-1:0] FUNCT_LSL = 4'd6;
    localparam logic [FUNCT_W-1:0] FUNCT_LSR = 4'd7;

    localparam int F_FUNCT_LSB = 28;
    localparam int F_IMM_SEL   = 27;
    localparam int F_RD_LSB    = 22;
    localparam int F_RS1_LSB   = 17;
    localparam int F_RS2_LSB   = 12;

    typedef struct packed {
        logic [REG_SIZE-1:0]    a;
        logic [REG_SIZE-1:0]    b;
        logic [OPCODE_SIZE-1:0] op;
        logic [REG_ADDR_W-1:0]  rd;
    } issue_bundle_t;

    // r0 is hardwired zero; otherwise writeback bypasses the file.
    function automatic logic [REG_SIZE-1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] idx,
        input logic [REG_SIZE-1:0]   rdata,
        input logic                  wbv,
        input logic [REG_ADDR_W-1:0] wbrd,
        input logic [REG_SIZE-1:0]   wbd
    );
        logic [REG_SIZE-1:0] r;
        r = rdata;
        if (idx == '0)
            r = '0;
        else if (wbv && (wbrd == idx))
            r = wbd;
        return r;
    endfunction

endpackage

// File: rtl/alu_issue_if.sv
// Fetch-side and ALU-side handshakes of the issue stage.
// master = issue stage, slave = its environment.
interface alu_issue_if;
    import alu_issue_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [INSTR_W-1:0]     in_instr;
    logic                   out_valid;
    logic                   out_ready;
    logic [REG_SIZE-1:0]    A;
    logic [REG_SIZE-1:0]    B;
    logic [OPCODE_SIZE-1:0] ALU_Op;
    logic [REG_ADDR_W-1:0]  out_rd;

    modport master (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, A, B, ALU_Op, out_rd
    );

    modport slave (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, A, B, ALU_Op, out_rd
    );

endinterface

// File: rtl/alu_funct_decode.sv
// Maps the instruction funct field onto ALU opcodes.
// Codes 8-15 are reported as illegal.
module alu_funct_decode
    import alu_issue_pkg::*;
(
    input  logic [FUNCT_W-1:0]     funct,
    output logic [OPCODE_SIZE-1:0] op,
    output logic                   legal
);

    // funct lookup; illegal codes decode to AND with legal low
    always_comb begin
        op    = ALU_AND;
        legal = 1'b1;
        unique case (funct)
            FUNCT_AND: op = ALU_AND;
            FUNCT_ORR: op = ALU_ORR;
            FUNCT_ADD: op = ALU_ADD;
            FUNCT_SUB: op = ALU_SUB;
            FUNCT_XOR: op = ALU_XOR;
            FUNCT_NOR: op = ALU_NOR;
            FUNCT_LSL: op = ALU_LSL;
            FUNCT_LSR: op = ALU_LSR;
            default:   legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode, operand read with writeback bypass, and registered
// issue bundle towards the ALU under valid/ready.
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_issue_if.master           io,
    output logic [REG_ADDR_W-1:0] rs1_addr,
    output logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [REG_SIZE-1:0]   rs1_data,
    input  logic [REG_SIZE-1:0]   rs2_data,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [REG_SIZE-1:0]   wb_data,
    output logic                  err_illegal,
    input  logic                  err_clr,
    output logic [CNT_W-1:0]      issue_count
);

    logic [INSTR_W-1:0]     instr_g;
    logic                   accept;
    logic                   dec_legal;
    logic [OPCODE_SIZE-1:0] dec_op;
    logic [REG_SIZE-1:0]    imm_ext;
    issue_bundle_t          nxt;
    issue_bundle_t          bundle_q;
    logic                   valid_q;

    // Idle cycles decode an all-zero word so X never leaks inward.
    assign instr_g  = io.in_valid ? io.in_instr : '0;
    assign rs1_addr = io.in_instr[F_RS1_LSB +: REG_ADDR_W];
    assign rs2_addr = io.in_instr[F_RS2_LSB +: REG_ADDR_W];

    assign io.in_ready = ~valid_q | io.out_ready;
    assign accept      = io.in_valid & io.in_ready;

    alu_funct_decode u_dec (
        .funct (instr_g[F_FUNCT_LSB +: FUNCT_W]),
        .op    (dec_op),
        .legal (dec_legal)
    );

    assign imm_ext = {{(REG_SIZE-IMM_W){instr_g[IMM_W-1]}},
                      instr_g[IMM_W-1:0]};

    // Assemble the candidate bundle from decoded fields
    always_comb begin
        nxt    = '0;
        nxt.a  = fwd_sel(instr_g[F_RS1_LSB +: REG_ADDR_W],
                         rs1_data, wb_valid, wb_rd, wb_data);
        nxt.b  = fwd_sel(instr_g[F_RS2_LSB +: REG_ADDR_W],
                         rs2_data, wb_valid, wb_rd, wb_data);
        if (instr_g[F_IMM_SEL])
            nxt.b = imm_ext;
        nxt.op = dec_op;
        nxt.rd = instr_g[F_RD_LSB +: REG_ADDR_W];
    end

    // Output register: load on legal accept, drain on ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            bundle_q <= '{a: '0, b: '0, op: ALU_AND, rd: '0};
        end else if (accept && dec_legal) begin
            valid_q  <= 1'b1;
            bundle_q <= nxt;
        end else if (io.out_ready) begin
            valid_q  <= 1'b0;
        end
    end

    // Sticky illegal flag; a new set beats a clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_illegal <= 1'b0;
        else if (accept && !dec_legal)
            err_illegal <= 1'b1;
        else if (err_clr)
            err_illegal <= 1'b0;
    end

    // Count completed transfers, wrapping freely
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            issue_count <= '0;
        else if (valid_q && io.out_ready)
            issue_count <= issue_count + 1'b1;
    end

    assign io.out_valid = valid_q;
    assign io.A         = bundle_q.a;
    assign io.B         = bundle_q.b;
    assign io.ALU_Op    = bundle_q.op;
    assign io.out_rd    = bundle_q.rd;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized and directed bench for alu_issue_stage against
// a behavioural model of the issue rules.
module tb_alu_issue_stage;
    import alu_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        err_illegal;
    logic        err_clr = 1'b0;
    logic [31:0] issue_count;

    logic [31:0] regs [32];
    int total = 0;
    int bad = 0;
    bit chk_en = 0;

    alu_issue_if bus ();

    alu_issue_stage #(.CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .io          (bus.master),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .err_illegal (err_illegal),
        .err_clr     (err_clr),
        .issue_count (issue_count)
    );

    always #5 clk = ~clk;

    assign rs1_data = regs[rs1_addr];
    assign rs2_data = regs[rs2_addr];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(int f, int ib, int rd,
                                       int r1, int r2, int imm);
        logic [31:0] w;
        w = {f[3:0], ib[0], rd[4:0], r1[4:0], r2[4:0], imm[11:0]};
        return w;
    endfunction

    // ---- behavioural model ----
    logic [3:0] op_tab [8] = '{ALU_AND, ALU_ORR, ALU_ADD, ALU_SUB,
                               ALU_XOR, ALU_NOR, ALU_LSL, ALU_LSR};
    logic        m_valid, m_err;
    logic [31:0] m_a, m_b, m_cnt;
    logic [3:0]  m_op;
    logic [4:0]  m_rd;
    logic        m_acc;
    logic [3:0]  m_f;

    assign m_acc = bus.in_valid && (!m_valid || bus.out_ready);
    assign m_f   = bus.in_instr[31:28];

    function automatic logic [31:0] opnd(input logic [4:0] i);
        if (i == 0) return 32'h0;
        if (wb_valid && wb_rd == i) return wb_data;
        return regs[i];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 0; m_err <= 0; m_cnt <= 0;
            m_a <= 0; m_b <= 0; m_op <= ALU_AND; m_rd <= 0;
        end else begin
            if (m_valid && bus.out_ready) m_cnt <= m_cnt + 1;
            if (m_acc && m_f < 8) begin
                m_valid <= 1;
                m_a  <= opnd(bus.in_instr[21:17]);
                m_b  <= bus.in_instr[27]
                        ? 32'($signed(bus.in_instr[11:0]))
                        : opnd(bus.in_instr[16:12]);
                m_op <= op_tab[m_f[2:0]];
                m_rd <= bus.in_instr[26:22];
            end else if (bus.out_ready) begin
                m_valid <= 0;
            end
            if (m_acc && m_f >= 8) m_err <= 1;
            else if (err_clr) m_err <= 0;
        end
    end

    // Compare on every falling edge once out of reset
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("m_in_ready", 32'(bus.in_ready),
                32'(!m_valid || bus.out_ready));
            chk("m_out_valid", 32'(bus.out_valid), 32'(m_valid));
            chk("m_err", 32'(err_illegal), 32'(m_err));
            chk("m_count", issue_count, m_cnt);
            if (m_valid) begin
                chk("m_A", bus.A, m_a);
                chk("m_B", bus.B, m_b);
                chk("m_op", 32'(bus.ALU_Op), 32'(m_op));
                chk("m_rd", 32'(bus.out_rd), 32'(m_rd));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] held_a, held_b, cnt0, r;
    logic [3:0]  f;

    initial begin
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        bus.in_valid = 0;
        bus.in_instr = '0;
        bus.out_ready = 0;
        repeat (3) step();
        rst_n = 1;
        chk_en = 1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_count", issue_count, 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);

        // ADD register form
        regs[3] = 32'h10; regs[4] = 32'h22;
        bus.out_ready = 1;
        bus.in_valid = 1;
        bus.in_instr = mk(2, 0, 5, 3, 4, 0);
        step();
        bus.in_valid = 0;
        chk("add_A", bus.A, 32'h10);
        chk("add_B", bus.B, 32'h22);
        chk("add_op", 32'(bus.ALU_Op), 32'(ALU_ADD));
        chk("add_rd", 32'(bus.out_rd), 32'd5);
        step();
        chk("add_count", issue_count, 32'd1);

        // immediate sign-extend, r0 reads zero
        regs[0] = 32'hDEAD;
        bus.in_valid = 1;
        bus.in_instr = mk(3, 1, 6, 0, 9, 12'hFFF);
        step();
        bus.in_valid = 0;
        chk("imm_A", bus.A, 32'h0);
        chk("imm_B", bus.B, 32'hFFFF_FFFF);
        chk("imm_op", 32'(bus.ALU_Op), 32'(ALU_SUB));

        // forwarding
        regs[7] = 32'h1;
        wb_valid = 1; wb_rd = 7; wb_data = 32'hABCD;
        bus.in_valid = 1;
        bus.in_instr = mk(0, 0, 1, 7, 2, 0);
        step();
        chk("fwd_A", bus.A, 32'hABCD);
        wb_rd = 0;
        bus.in_instr = mk(0, 0, 1, 0, 2, 0);
        step();
        bus.in_valid = 0;
        wb_valid = 0;
        chk("fwd_r0_A", bus.A, 32'h0);
        step();

        // backpressure
        bus.out_ready = 0;
        bus.in_valid = 1;
        bus.in_instr = mk(4, 0, 9, 3, 4, 0);
        step();
        held_a = bus.A; held_b = bus.B; cnt0 = issue_count;
        chk("bp_first_rd", 32'(bus.out_rd), 32'd9);
        bus.in_instr = mk(1, 0, 10, 1, 2, 0);
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            step();
            chk("bp_rd", 32'(bus.out_rd), 32'd9);
            chk("bp_A", bus.A, held_a);
            chk("bp_B", bus.B, held_b);
            chk("bp_count", issue_count, cnt0);
        end

        // reset while a bundle is held
        bus.in_valid = 0;
        #1 rst_n = 0;
        #1;
        chk("mrst_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_A", bus.A, 32'd0);
        chk("mrst_B", bus.B, 32'd0);
        chk("mrst_op", 32'(bus.ALU_Op), 32'(ALU_AND));
        chk("mrst_rd", 32'(bus.out_rd), 32'd0);
        chk("mrst_count", issue_count, 32'd0);
        chk("mrst_err", 32'(err_illegal), 32'd0);
        step();
        rst_n = 1;
        chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);

        // four back-to-back
        bus.out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            bus.in_valid = 1;
            bus.in_instr = mk(k, 0, k + 1, k + 1, k + 2, 0);
            step();
            chk("b2b_valid", 32'(bus.out_valid), 32'd1);
            chk("b2b_rd", 32'(bus.out_rd), 32'(k + 1));
        end
        bus.in_valid = 0;
        step();
        chk("b2b_count", issue_count, 32'd4);
        chk("b2b_drain", 32'(bus.out_valid), 32'd0);

        // illegal funct and clear race
        bus.in_valid = 1;
        bus.in_instr = mk(12, 0, 3, 1, 1, 0);
        step();
        chk("ill_valid", 32'(bus.out_valid), 32'd0);
        chk("ill_err", 32'(err_illegal), 32'd1);
        err_clr = 1;
        bus.in_instr = mk(15, 1, 3, 1, 1, 5);
        step();
        chk("ill_race_err", 32'(err_illegal), 32'd1);
        bus.in_valid = 0;
        step();
        err_clr = 0;
        chk("ill_clr_err", 32'(err_illegal), 32'd0);

        // randomized traffic
        for (int c = 0; c < 600; c++) begin
            r = $urandom;
            f = ($urandom % 8 == 0) ? 4'(8 + $urandom % 8)
                                    : 4'($urandom % 8);
            bus.in_valid  = ($urandom % 4) != 0;
            bus.out_ready = ($urandom % 3) != 0;
            bus.in_instr  = {f, r[27], r[26:22], 2'b00, r[19:17],
                             2'b00, r[14:12], r[11:0]};
            wb_valid = $urandom % 2;
            wb_rd    = 5'($urandom % 8);
            wb_data  = $urandom;
            err_clr  = ($urandom % 10) == 0;
            if ($urandom % 4 == 0) regs[$urandom % 8] = $urandom;
            step();
        end
        bus.in_valid = 0;
        bus.out_ready = 1;
        err_clr = 0;
        repeat (3) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Producer end of the ALU operand/opcode interface: decodes an instruction word, reads two source registers, and selects immediate vs register for B.
- Forwards writeback data onto the operands and presents a registered {A, B, ALU_Op, rd} bundle to the ALU under a valid/ready handshake.
- Sits between fetch and the ALU. Flags illegal function codes and counts issued operations.

Parameters:
- REG_SIZE, 32, operand/data width (shared package constant).
- OPCODE_SIZE, 4, ALU_Op width (shared package constant).
- REG_ADDR_W, 5, register index width.
- CNT_W, 32, issue counter width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low (one clock, asynchronous active-low reset).
- in_valid  in  1  instruction valid.
- in_ready  out  1  stage can accept.
- in_instr  in  32  instruction word.
- rs1_addr  out  REG_ADDR_W  register file read address 1, combinational from in_instr[21:17].
- rs2_addr  out  REG_ADDR_W  register file read address 2, combinational from in_instr[16:12].
- rs1_data  in  REG_SIZE  register file read data 1, same cycle.
- rs2_data  in  REG_SIZE  register file read data 2, same cycle.
- wb_valid  in  1  writeback valid.
- wb_rd  in  REG_ADDR_W  writeback destination.
- wb_data  in  REG_SIZE  writeback value.
- out_valid  out  1  issue bundle valid.
- out_ready  in  1  ALU side accepts.
- A  out  REG_SIZE  operand A.
- B  out  REG_SIZE  operand B.
- ALU_Op  out  OPCODE_SIZE  operation.
- out_rd  out  REG_ADDR_W  destination register.
- err_illegal  out  1  sticky illegal-function flag.
- err_clr  in  1  clears err_illegal.
- issue_count  out  CNT_W  number of issued bundles.

Behaviour:
- Instruction format:
  - [31:28] funct: 0 AND, 1 ORR, 2 ADD, 3 SUB, 4 XOR, 5 NOR, 6 LSL, 7 LSR; 8-15 illegal.
  - [27] imm select; [26:22] rd; [21:17] rs1; [16:12] rs2; [11:0] imm12, sign-extended to REG_SIZE.
- funct maps to the ALU_AND..ALU_LSR encodings in the shared package.
- Reset: out_valid=0, A=0, B=0, ALU_Op=ALU_AND, out_rd=0, err_illegal=0, issue_count=0. A reset asserted mid-transfer drops any held bundle immediately.
- in_ready = ~out_valid | out_ready (combinational). Accept occurs when in_valid & in_ready.
- Operand read in the accept cycle, in priority order:
  - index 0 reads as 0, regardless of rs*_data or wb.
  - else if wb_valid & wb_rd==index & wb_rd!=0: take wb_data.
  - else take rs*_data.
- B = imm12 sign-extended when [27]=1, else the rs2 value. rs2 forwarding is irrelevant when [27]=1.
- Latency: one cycle. A legal accept at edge N gives out_valid=1 with the bundle after edge N.
- Output register behaviour:
  - Holds stable while out_valid & ~out_ready (no change on A/B/ALU_Op/out_rd).
  - out_valid falls when out_ready=1 and no new legal accept occurs.
  - Back-to-back legal accepts with out_ready=1 give one bundle per cycle, with no bubble.
- Illegal funct: the instruction is consumed when accepted, but no bundle is produced (out_valid follows the "no new accept" rule) and err_illegal is set.
- err_illegal: set and err_clr in the same cycle → set wins. err_clr alone clears it the next cycle.
- issue_count increments by 1 on each out_valid & out_ready cycle and wraps modulo 2^CNT_W, with no saturation.
- No hazard stalls: forwarding covers only the writeback bus. Older in-flight results are the upstream pipeline's responsibility.
- X-safety: outputs hold their previous values when in_valid=0. Decode must not propagate X from in_instr when in_valid=0.

Decomposition:
- Shared package (existing constants header):
  - REG_SIZE, OPCODE_SIZE, ALU_* encodings.
  - New: REG_ADDR_W, FUNCT_* codes, instruction field positions, and a packed struct issue_bundle_t {A, B, ALU_Op, rd}.
- Sub-module alu_funct_decode: combinational funct → {ALU_Op, legal}.
- Forwarding mux and pipeline register stay inline.

Test Plan:
- Reset then idle: rst_n low mid-run with out_valid=1 → all outputs at reset values immediately. After release, in_ready=1 and issue_count=0.
- ADD, register form: funct=2, rs1=3 (data 0x10), rs2=4 (data 0x22), rd=5, out_ready=1 → next cycle A=0x10, B=0x22, ALU_Op=ALU_ADD, out_rd=5, issue_count=1.
- Immediate sign-extend plus r0: funct=3, imm=1, rs1=0, imm12=0xFFF → A=0, B=0xFFFFFFFF, ALU_Op=ALU_SUB.
- Forwarding priority:
  - rs1=7, rs1_data=0x1, wb_valid=1, wb_rd=7, wb_data=0xABCD → A=0xABCD.
  - Same with rs1=0, wb_rd=0 → A=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, bundle stable, no count change. Then out_ready=1 for 4 back-to-back instructions → 4 bundles on consecutive cycles, issue_count=4.
- Illegal plus clear race: funct=0xC → no out_valid, err_illegal=1. Another illegal in the same cycle as err_clr=1 → err_illegal stays 1. err_clr alone → 0.
